multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Control sequencer for the multi-cycle variant of the CPU datapath (PC, instruction/data memory, register file, Imm_gen, ALU, operand mux). It steps each instruction through fetch, decode, execute, memory and writeback phases. It drives per-cycle strobes and mux selects, and handshakes with a shared, variable-latency memory port. It also counts retired instructions and traps on illegal opcodes or memory timeout.

Parameters:
WAIT_LIMIT, 16, max cycles a memory request may wait for mem_ready before trap
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read (valid with mem_req)
iord  output  1  memory address select: 0 = PC, 1 = ALU result register
ir_write  output  1  latch instruction register
pc_write  output  1  update PC
pc_src  output  1  0 = PC+4, 1 = branch target register
alu_src  output  1  0 = ReadData2, 1 = Imm_out
alu_control  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
reg_write  output  1  register file write enable
mem_to_reg  output  1  writeback select: 0 = ALU, 1 = memory data
trap  output  1  sticky error flag
retired  output  CNT_W  count of completed instructions
state  output  4  current state encoding, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=15.
- Reset (sync, highest priority): state=FETCH, retired=0, trap=0, wait counter=0.
- While reset is high, all strobes (mem_req, ir_write, pc_write, reg_write) are 0. Reset asserted mid-instruction aborts it with no register, memory or PC side effects on later cycles.
- Outputs are Moore functions of state, except pc_write in BRANCH. All outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0.
  - When mem_ready=1: ir_write=1, pc_write=1 (pc_src=0), next state DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE (1 cycle): alu_control=ADD computes the branch target. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - anything else -> TRAP
- EXEC_R: alu_src=0; alu_control from funct3/funct7b5:
  - 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 010 SLT
  - any other combination -> TRAP instead of WB_ALU
- EXEC_I: alu_src=1; same funct3 mapping with funct7b5 ignored (000 = ADD). Unsupported funct3 -> TRAP.
- WB_ALU: reg_write=1, mem_to_reg=0, then FETCH.
- MEM_ADDR: alu_src=1, alu_control=ADD. Next state MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, mem_we=0, iord=1; wait for mem_ready, then WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1; wait for mem_ready, then FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, then FETCH.
- BRANCH: alu_src=0, alu_control=SUB, pc_src=1, pc_write=zero. Next state FETCH.
- Handshake rules:
  - mem_req, mem_we and iord hold stable until the cycle mem_ready=1.
  - A request completes in the same cycle mem_ready is seen, so the minimum memory latency is 1 cycle.
  - mem_ready while mem_req=0 is ignored.
- Timeout: the wait counter clears when a request completes or the FSM leaves a memory state. If the counter reaches WAIT_LIMIT with mem_ready still 0, next state is TRAP.
- TRAP:
  - all strobes are 0 and trap=1
  - the FSM stays in TRAP until reset
  - retired does not increment
- retired increments by 1 on the final cycle of each instruction: WB_ALU, WB_MEM, the completing cycle of MEM_WR, and BRANCH. It wraps modulo 2^CNT_W.
- Zero-wait latencies:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles

Test Plan:
- Reset, then R-type add: opcode=0110011, funct3=000, funct7b5=0, mem_ready=1 -> states 0,1,2,7,0; alu_control=0010 in EXEC_R; reg_write=1 for exactly 1 cycle; retired=1.
- Load with 3-cycle memory delay in MEM_RD: opcode=0000011 -> mem_req, mem_we and iord held steady for 3 cycles; then WB_MEM with mem_to_reg=1 and reg_write=1; retired increments once.
- BEQ: opcode=1100011, once with zero=1 and once with zero=0 -> pc_write=1 with pc_src=1 in the first case; pc_write=0 in the second; both take 3 cycles.
- Illegal opcode 1111111 -> TRAP after DECODE; trap=1; no strobes for 50 cycles; reset returns state=0 and trap=0.
- Timeout: mem_ready held 0 in FETCH -> TRAP entered after exactly 16 waiting cycles.
- Reset asserted during MEM_WR with mem_ready=0 -> next cycle state=0, mem_req=0, retired=0; no write completes.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute/memory/writeback phases,
// memory handshake with wait timeout, retired-instruction counter and sticky trap.
module multicycle_control_fsm #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [3:0]       alu_control,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_TRAP     = 4'd15
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              trap_q, trap_d;

    // Returns {legal, alu_control}; sub_sel is only meaningful for R-type.
    function automatic logic [4:0] alu_decode(input logic [2:0] f3, input logic sub_sel);
        logic [4:0] r;
        r = {1'b0, ALU_AND};
        case (f3)
            3'b000:  r = {1'b1, sub_sel ? ALU_SUB : ALU_ADD};
            3'b111:  r = {1'b1, ALU_AND};
            3'b110:  r = {1'b1, ALU_OR};
            3'b010:  r = {1'b1, ALU_SLT};
            default: r = {1'b0, ALU_AND};
        endcase
        return r;
    endfunction

    always_comb begin
        logic legal;
        legal       = 1'b0;
        state_d     = state_q;
        wait_d      = '0;
        retired_d   = retired_q;
        trap_d      = trap_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src     = 1'b0;
        alu_control = ALU_AND;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_control = ALU_ADD;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                {legal, alu_control} = alu_decode(funct3, funct7b5);
                state_d = legal ? S_WB_ALU : S_TRAP;
            end
            S_EXEC_I: begin
                alu_src = 1'b1;
                {legal, alu_control} = alu_decode(funct3, 1'b0);
                state_d = legal ? S_WB_ALU : S_TRAP;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src     = 1'b1;
                alu_control = ALU_ADD;
                state_d     = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retired_d  = retired_q + CNT_W'(1);
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_control = ALU_SUB;
                pc_src      = 1'b1;
                pc_write    = zero;
                retired_d   = retired_q + CNT_W'(1);
                state_d     = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // A pending request that has used its whole wait budget traps instead of waiting again.
        if (mem_req && !mem_ready) begin
            if (wait_q == WAIT_LAST) state_d = S_TRAP;
            else                     wait_d  = wait_q + WCNT_W'(1);
        end

        if (state_d == S_TRAP) trap_d = 1'b1;

        if (reset) begin
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
        end
    end

    assign state   = state_q;
    assign trap    = trap_q;
    assign retired = retired_q;

endmodule
